// File: rtl/la_rng_pkg.sv
// rtl/la_rng_pkg.sv - shared types and constants for the laRNG conditioner
// Purpose: pair-FSM state encoding, default sizing, saturation helper.
// Ports: none (package).
package la_rng_pkg;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_HAVE_FIRST = 1'b1
  } pair_state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  // All-ones value for a counter of width w (w up to 64), used as the
  // saturation ceiling of the discard counter.
  function automatic logic [63:0] sat_max(input int w);
    if (w >= 64) sat_max = '1;
    else         sat_max = (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/la_rng_vn_extractor.sv
// rtl/la_rng_vn_extractor.sv - Von Neumann pair extractor with discard counter
// Purpose: debias raw bits pairwise (01->0, 10->1, 00/11 discarded) or pass
//          them straight through in bypass.
// Ports:
//   wb_clk_i, rst_n        clock, async active-low reset
//   i_en, i_bypass         enable (low flushes pair state), debias bypass
//   i_raw_bit, i_raw_valid raw entropy input
//   o_bit, o_stb           emitted bit and its strobe (same cycle as input)
//   o_discard_cnt          saturating count of discarded pairs
module la_rng_vn_extractor
  import la_rng_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_bypass,
  input  logic             i_raw_bit,
  input  logic             i_raw_valid,
  output logic             o_bit,
  output logic             o_stb,
  output logic [CNT_W-1:0] o_discard_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  pair_state_e      r_state;
  pair_state_e      w_next;
  logic             r_first;
  logic             w_load_first;
  logic             w_discard;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_first <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_first) r_first <= i_raw_bit;
      if (w_discard && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_load_first = 1'b0;
    w_discard    = 1'b0;
    o_bit        = i_raw_bit;
    o_stb        = 1'b0;
    // Disable or bypass both park the FSM, dropping any half-collected pair.
    if (!i_en || i_bypass) w_next = ST_IDLE;
    if (i_en && i_raw_valid) begin
      if (i_bypass) begin
        o_stb = 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_next       = ST_HAVE_FIRST;
            w_load_first = 1'b1;
          end
          ST_HAVE_FIRST: begin
            w_next = ST_IDLE;
            if (r_first != i_raw_bit) begin
              // 01 -> 0, 10 -> 1: the emitted bit equals the first bit.
              o_stb = 1'b1;
              o_bit = r_first;
            end else begin
              w_discard = 1'b1;
            end
          end
          default: w_next = ST_IDLE;
        endcase
      end
    end
  end

  assign o_discard_cnt = r_cnt;

endmodule

// File: rtl/la_rng_conditioner.sv
// rtl/la_rng_conditioner.sv - laRNG entropy conditioner top
// Purpose: debias raw bits, pack them MSB-first into WIDTH-bit words and
//          present words on a valid/ready port with sticky overflow.
// Ports:
//   wb_clk_i, rst_n           clock, async active-low reset
//   en, bypass                enable (low flushes pair/packer), debias bypass
//   raw_bit, raw_valid        raw entropy input
//   rd_valid, rd_ready, rd_data  word output handshake
//   overflow, clr_overflow    sticky dropped-word flag and its clear
//   discard_cnt               saturating count of discarded pairs
module la_rng_conditioner
  import la_rng_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bypass,
  input  logic             raw_bit,
  input  logic             raw_valid,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [CNT_W-1:0] discard_cnt
);

  localparam int BC_W = $clog2(WIDTH);

  logic             w_bit;
  logic             w_stb;
  logic [WIDTH-1:0] r_shift;
  logic [BC_W-1:0]  r_bitcnt;
  logic [WIDTH-1:0] w_word;
  logic             w_complete;
  logic             w_slot_free;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_overflow;

  la_rng_vn_extractor #(.CNT_W(CNT_W)) u_vn (
    .wb_clk_i      (wb_clk_i),
    .rst_n         (rst_n),
    .i_en          (en),
    .i_bypass      (bypass),
    .i_raw_bit     (raw_bit),
    .i_raw_valid   (raw_valid),
    .o_bit         (w_bit),
    .o_stb         (w_stb),
    .o_discard_cnt (discard_cnt)
  );

  assign w_word      = {r_shift[WIDTH-2:0], w_bit};
  assign w_complete  = w_stb && (r_bitcnt == BC_W'(WIDTH - 1));
  // The slot counts as free when the current word is being consumed now.
  assign w_slot_free = !r_rd_valid || rd_ready;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (!en) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_stb) begin
      r_shift  <= w_word;
      r_bitcnt <= w_complete ? '0 : r_bitcnt + BC_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_complete && w_slot_free) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_word;
      end else if (rd_ready) begin
        r_rd_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_complete && !w_slot_free) r_overflow <= 1'b1;
      else if (clr_overflow)          r_overflow <= 1'b0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_la_rng_conditioner.sv
// tb/tb_la_rng_conditioner.sv - scoreboard bench for la_rng_conditioner
module tb_la_rng_conditioner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        bypass = 1'b0;
  logic        raw_bit = 1'b0;
  logic        raw_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  logic [3:0]  discard_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  la_rng_conditioner #(.WIDTH(32), .CNT_W(4)) dut (
    .wb_clk_i     (clk),
    .rst_n        (rst_n),
    .en           (en),
    .bypass       (bypass),
    .raw_bit      (raw_bit),
    .raw_valid    (raw_valid),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .discard_cnt  (discard_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each handshake observed on the output pops the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", {32'd0, rd_data}, 64'hx_dead);
      else                   check("word", {32'd0, rd_data}, {32'd0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    tick(1);
    raw_valid = 1'b0;
  endtask

  task automatic send_range(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  task automatic send_pair(input logic a, input logic b);
    send_bit(a);
    send_bit(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_rd_data", {32'd0, rd_data}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_discard", {60'd0, discard_cnt}, 64'd0);

    // Bypass: straight packing, 1-cycle latency.
    en = 1'b1; bypass = 1'b1; rd_ready = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    send_range(32'hDEADBEEF, 31, 1);
    check("byp_not_early", {63'd0, rd_valid}, 64'd0);
    send_range(32'hDEADBEEF, 0, 0);
    check("byp_latency", {63'd0, rd_valid}, 64'd1);
    check("byp_data", {32'd0, rd_data}, 64'hDEADBEEF);
    check("byp_ovf", {63'd0, overflow}, 64'd0);
    tick(2);

    // Debias: 10,01 emit 1,0; 00,11 discarded.
    bypass = 1'b0;
    send_pair(1, 0); send_pair(0, 1); send_pair(0, 0); send_pair(1, 1);
    check("vn_discard2", {60'd0, discard_cnt}, 64'd2);
    exp_q.push_back(32'hBFFFFFFF);
    for (int i = 0; i < 30; i++) send_pair(1, 0);
    check("vn_valid", {63'd0, rd_valid}, 64'd1);
    check("vn_data", {32'd0, rd_data}, 64'hBFFFFFFF);
    tick(2);

    // Bypass toggled mid-pair drops the stored first bit.
    send_bit(0);
    bypass = 1'b1; tick(1); bypass = 1'b0;
    exp_q.push_back(32'hFFFFFFFF);
    for (int i = 0; i < 32; i++) send_pair(1, 0);
    check("midpair_data", {32'd0, rd_data}, 64'hFFFFFFFF);
    tick(2);

    // Overflow: second word dropped, first held.
    bypass = 1'b1; rd_ready = 1'b0;
    send_range(32'h12345678, 31, 0);
    send_range(32'h9ABCDEF0, 31, 1);
    check("ovf_not_early", {63'd0, overflow}, 64'd0);
    send_range(32'h9ABCDEF0, 0, 0);
    check("ovf_set", {63'd0, overflow}, 64'd1);
    check("ovf_held_data", {32'd0, rd_data}, 64'h12345678);
    clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
    check("ovf_clr", {63'd0, overflow}, 64'd0);
    check("ovf_clr_data", {32'd0, rd_data}, 64'h12345678);
    check("ovf_clr_valid", {63'd0, rd_valid}, 64'd1);
    exp_q.push_back(32'h12345678);
    rd_ready = 1'b1;
    tick(2);
    check("drain_valid", {63'd0, rd_valid}, 64'd0);

    // Consume and load in the same cycle.
    rd_ready = 1'b0;
    exp_q.push_back(32'hC0FFEE11);
    send_range(32'hC0FFEE11, 31, 0);
    exp_q.push_back(32'h5A5AA5A5);
    send_range(32'h5A5AA5A5, 31, 1);
    rd_ready = 1'b1;
    send_range(32'h5A5AA5A5, 0, 0);
    check("sim_valid", {63'd0, rd_valid}, 64'd1);
    check("sim_data", {32'd0, rd_data}, 64'h5A5AA5A5);
    check("sim_ovf", {63'd0, overflow}, 64'd0);
    tick(2);

    // Reset after 17 bits flushes the packer.
    send_range(32'hFFFFFFFF, 16, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, rd_valid}, 64'd0);
    check("async_rst_data", {32'd0, rd_data}, 64'd0);
    tick(1);
    rst_n = 1'b1;
    exp_q.push_back(32'h0F0F1234);
    send_range(32'h0F0F1234, 31, 0);
    check("rstflush_data", {32'd0, rd_data}, 64'h0F0F1234);
    tick(2);

    // en=0 for one cycle flushes the packer, keeps discard_cnt.
    bypass = 1'b0;
    send_pair(0, 0); send_pair(1, 1);
    bypass = 1'b1;
    send_range(32'hFFFFFFFF, 16, 0);
    en = 1'b0; tick(1); en = 1'b1;
    exp_q.push_back(32'hA5C30FF0);
    send_range(32'hA5C30FF0, 31, 0);
    check("enflush_data", {32'd0, rd_data}, 64'hA5C30FF0);
    check("enflush_discard", {60'd0, discard_cnt}, 64'd2);
    tick(2);

    // Discard counter saturation at 4 bits.
    do_reset();
    bypass = 1'b0;
    for (int i = 0; i < 14; i++) send_pair(0, 0);
    check("sat_14", {60'd0, discard_cnt}, 64'd14);
    send_pair(0, 0);
    check("sat_15", {60'd0, discard_cnt}, 64'd15);
    for (int i = 0; i < 5; i++) send_pair(0, 0);
    check("sat_hold", {60'd0, discard_cnt}, 64'd15);

    tick(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/la_rng_conditioner.md
Name: la_rng_conditioner

Overview:
- Conditions the raw entropy bitstream of the laRNG user project into full-width random words for the logic-analyzer/readout side.
- Sits directly downstream of the raw bit source (LA-driven or on-chip sampler):
  - removes bias with a Von Neumann extractor (optional bypass);
  - packs surviving bits into WIDTH-bit words;
  - presents each word on a valid/ready interface with sticky overflow reporting.

Parameters:
- WIDTH, 32, output word width in bits; legal range 2..64.
- CNT_W, 16, width of the saturating discard counter.

Ports:
- wb_clk_i  input  1  single block clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  conditioner enable; low flushes the pair and partial-word state.
- bypass  input  1  1 = each raw bit goes straight to the packer (no debias).
- raw_bit  input  1  raw entropy bit.
- raw_valid  input  1  raw_bit is sampled this cycle.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- rd_valid  output  1  rd_data holds an unread word.
- rd_data  output  WIDTH  conditioned word; the first packed bit is at the MSB.
- overflow  output  1  sticky: a completed word was dropped.
- clr_overflow  input  1  synchronous clear of overflow.
- discard_cnt  output  CNT_W  saturating count of discarded pairs (00/11).

Behaviour:
- Reset (rst_n low, asynchronous):
  - outputs: rd_valid=0, rd_data=0, overflow=0, discard_cnt=0;
  - internal: pair FSM=IDLE, bit counter=0, shift register=0.
- Raw bits are consumed only when en=1 and raw_valid=1.
- Debias FSM (bypass=0), states IDLE and HAVE_FIRST:
  - IDLE + accepted bit: store bit as first, go to HAVE_FIRST.
  - HAVE_FIRST + accepted bit b2, return to IDLE:
    - first=0, b2=1 -> emit 0;
    - first=1, b2=0 -> emit 1;
    - equal bits -> emit nothing, discard_cnt+1 (saturates at all-ones).
- bypass=1: every accepted bit is emitted the same cycle and the FSM is held in IDLE.
  - Changing bypass mid-pair drops the stored first bit (FSM forced to IDLE).
- Packer:
  - each emitted bit does shift <= {shift[WIDTH-2:0], bit} and bit counter +1;
  - the bit emitted when the counter = WIDTH-1 completes a word;
  - on completion the counter returns to 0.
- Word completion at cycle N:
  - output slot free, or rd_valid && rd_ready at N: load rd_data with the full word; rd_valid=1 at N+1. Latency from the completing raw bit to rd_valid is 1 cycle.
  - otherwise: drop the word, keep rd_data unchanged, set overflow at N+1.
- Handshake:
  - transfer happens when rd_valid && rd_ready; with no new load, rd_valid goes 0 next cycle;
  - load and consume in the same cycle: the new word loads and rd_valid stays 1;
  - rd_data is stable while rd_valid=1 && rd_ready=0;
  - rd_ready while rd_valid=0 has no effect.
- overflow:
  - clr_overflow=1 clears it next cycle;
  - a new overflow event in the same cycle as clr_overflow wins (overflow stays 1).
- en=0 (synchronous):
  - FSM to IDLE, bit counter=0, shift register=0;
  - rd_valid/rd_data, overflow and discard_cnt are retained, and the handshake still operates.
- discard_cnt clears only on reset.

Decomposition:
- Shared package la_rng_pkg:
  - pair-FSM state enum (IDLE, HAVE_FIRST);
  - default WIDTH/CNT_W constants;
  - a function returning the all-ones saturation value.
- One natural sub-module: la_rng_vn_extractor (the pair FSM plus discard counter). Output: emitted bit + strobe.
- The packer and output register stay in the top module.

Test Plan:
- bypass=1, en=1: feed the 32 bits of 0xDEADBEEF MSB first on consecutive cycles, rd_ready=1 -> rd_valid=1 exactly one cycle after the last bit, rd_data=0xDEADBEEF, overflow=0.
- bypass=0: feed pairs 10,01,00,11 -> packer receives 1,0 (counter=2), discard_cnt=2. Then 30 more 10 pairs -> rd_data=0xBFFFFFFF.
- Overflow: rd_ready=0, complete two words in bypass -> the first word is held, overflow=1 after the second completes. A clr_overflow pulse -> overflow=0 and rd_data still holds the first word.
- Simultaneous consume and load: rd_valid=1 and rd_ready=1 in the cycle a new word completes -> rd_valid stays 1, rd_data updates, overflow=0.
- Reset and enable flush:
  - assert rst_n=0 after 17 bits, release and feed 32 bits -> the word contains only the post-reset bits;
  - repeat using en=0 for one cycle instead of reset -> same result, and discard_cnt is retained.
- Saturation: with CNT_W=4, feed 20 "00" pairs -> discard_cnt=15 and holds there.
